audio_record_play_core: RTL and testbench

Record/playback core for the two-clip audio recorder. It contains the control FSM, the shared sample-address counter and the PDM microphone deserializer. Recorded 16-bit words go to one of two external single-port memories. Playback streams words from the selected memory to the external PWM serializer. Inputs are already synchronized upstream.

---
 rtl/audio_record_play_core.sv | 211 +++++++++++++++++++++
 tb/tb_audio_record_play_core.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_record_play_core.sv
// rtl/audio_record_play_core.sv - record/playback control FSM, shared sample address counter and PDM deserializer
//
// Purpose: two-clip audio recorder core. RECORD deserializes PDM microphone bits
// into WORD_LENGTH-bit words and writes them to the selected external memory.
// PLAY holds the selected memory enabled for reading and advances the address each
// time the external serializer consumes a word.
//
// Optional feature macro: ABORT_ON_REPEAT_EN
//   defined   : a repeat edge of the active command returns to IDLE (partial word dropped)
//   undefined : repeat edges while busy are ignored
//
// Ports:
//   clock_i, reset_i            system clock (rising edge), asynchronous active-low reset
//   play_command_i              playback request, rising-edge detected
//   record_command_i            record request, rising-edge detected
//   play_clip_select_i          clip used for playback
//   record_clip_select_i        clip used for recording
//   playing_o, recording_o      state indicators
//   play_clip_o, record_clip_o  zero-extended clip indices for the display
//   serializer_done_i           serializer consumed the current word (one-cycle pulse)
//   serializer_enable_o         serializer enable, high in PLAY
//   pdm_clk_o, pdm_data_i       microphone clock out / data in
//   memory_rw_o                 1 = write, 0 = read
//   memory_address_o            current sample address
//   memory_0_enable_o           memory 0 enable
//   memory_1_enable_o           memory 1 enable
//   memory_data_o               last deserialized word

module audio_record_play_core #(
  parameter int WORD_LENGTH        = 16,
  parameter int SYSTEM_FREQUENCY   = 100,
  parameter int SAMPLING_FREQUENCY = 10,
  parameter int ADDR_WIDTH         = 17,
  parameter int MEMORY_DEPTH       = 131072
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   play_command_i,
  input  logic                   record_command_i,
  input  logic                   play_clip_select_i,
  input  logic                   record_clip_select_i,
  output logic                   playing_o,
  output logic                   recording_o,
  output logic [3:0]             play_clip_o,
  output logic [3:0]             record_clip_o,
  input  logic                   serializer_done_i,
  output logic                   serializer_enable_o,
  output logic                   pdm_clk_o,
  input  logic                   pdm_data_i,
  output logic                   memory_rw_o,
  output logic [ADDR_WIDTH-1:0]  memory_address_o,
  output logic                   memory_0_enable_o,
  output logic                   memory_1_enable_o,
  output logic [WORD_LENGTH-1:0] memory_data_o
);

  localparam int HALF_PERIOD = SYSTEM_FREQUENCY / (2 * SAMPLING_FREQUENCY);
  localparam int DIV_W       = $clog2(HALF_PERIOD + 1);
  localparam int CNT_W       = $clog2(WORD_LENGTH);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_DEPTH - 1);
  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0]      BIT_LAST  = CNT_W'(WORD_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   play_cmd_q, record_cmd_q;
  logic                   play_sel_q, record_sel_q;
  logic [ADDR_WIDTH-1:0]  address_q;
  logic [DIV_W-1:0]       div_q;
  logic                   pdm_clk_q;
  logic [WORD_LENGTH-2:0] shift_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [WORD_LENGTH-1:0] data_q;
  logic                   wr_strobe_q;

  logic                   play_edge, record_edge;
  logic                   sample_now, word_done;
  logic                   record_last, play_last;
  logic [WORD_LENGTH-1:0] shift_next;

  assign play_edge   = play_command_i & ~play_cmd_q;
  assign record_edge = record_command_i & ~record_cmd_q;

  // Sample on the system cycle whose closing edge drives pdm_clk_o high.
  assign sample_now  = (state_q == RECORD) && (div_q == DIV_LAST) && !pdm_clk_q;
  assign word_done   = sample_now && (bit_cnt_q == BIT_LAST);
  assign shift_next  = {shift_q, pdm_data_i};

  assign record_last = wr_strobe_q && (address_q == LAST_ADDR);
  assign play_last   = (state_q == PLAY) && serializer_done_i && (address_q == LAST_ADDR);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (record_edge) begin
          state_d = RECORD;
        end else if (play_edge) begin
          state_d = PLAY;
        end
      end
      RECORD: begin
        if (record_last) begin
          state_d = IDLE;
        end
`ifdef ABORT_ON_REPEAT_EN
        else if (record_edge) begin
          state_d = IDLE;
        end
`endif
      end
      PLAY: begin
        if (play_last) begin
          state_d = IDLE;
        end
`ifdef ABORT_ON_REPEAT_EN
        else if (play_edge) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      play_cmd_q   <= 1'b0;
      record_cmd_q <= 1'b0;
      play_sel_q   <= 1'b0;
      record_sel_q <= 1'b0;
      address_q    <= '0;
      div_q        <= '0;
      pdm_clk_q    <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      wr_strobe_q  <= 1'b0;
    end else begin
      play_cmd_q   <= play_command_i;
      record_cmd_q <= record_command_i;

      // Selects track the switches while idle; the value seen on the
      // starting edge is what stays latched for the whole operation.
      if (state_q == IDLE) begin
        play_sel_q   <= play_clip_select_i;
        record_sel_q <= record_clip_select_i;
      end

      // Any path back to IDLE (end of clip, abort) lands on address 0.
      if (state_d == IDLE) begin
        address_q <= '0;
      end else if ((state_q == RECORD) && wr_strobe_q) begin
        address_q <= address_q + ADDR_WIDTH'(1);
      end else if ((state_q == PLAY) && serializer_done_i) begin
        address_q <= address_q + ADDR_WIDTH'(1);
      end

      // A word completed in a cycle that leaves RECORD is never written.
      wr_strobe_q <= word_done && (state_d == RECORD);
      if (word_done && (state_d == RECORD)) begin
        data_q <= shift_next;
      end

      if ((state_q == RECORD) && (state_d == RECORD)) begin
        if (div_q == DIV_LAST) begin
          div_q     <= '0;
          pdm_clk_q <= ~pdm_clk_q;
          if (!pdm_clk_q) begin
            shift_q   <= shift_next[WORD_LENGTH-2:0];
            bit_cnt_q <= (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
          end
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
      end else begin
        div_q     <= '0;
        pdm_clk_q <= 1'b0;
        shift_q   <= '0;
        bit_cnt_q <= '0;
      end
    end
  end

  assign playing_o           = (state_q == PLAY);
  assign recording_o         = (state_q == RECORD);
  assign serializer_enable_o = (state_q == PLAY);
  assign play_clip_o         = {3'b000, play_sel_q};
  assign record_clip_o       = {3'b000, record_sel_q};
  assign pdm_clk_o           = pdm_clk_q;
  assign memory_rw_o         = wr_strobe_q;
  assign memory_address_o    = address_q;
  assign memory_data_o       = data_q;
  assign memory_0_enable_o   = ((state_q == PLAY) && !play_sel_q) || (wr_strobe_q && !record_sel_q);
  assign memory_1_enable_o   = ((state_q == PLAY) && play_sel_q) || (wr_strobe_q && record_sel_q);

endmodule

// File: tb/tb_audio_record_play_core.sv
// tb/tb_audio_record_play_core.sv - self-checking bench for audio_record_play_core

module tb_audio_record_play_core;

  localparam int W      = 16;
  localparam int AW     = 17;
  localparam int DEPTH  = 4;
  localparam int HALF   = 5;
  localparam int PERIOD = 10;

  logic          clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          play_cmd = 1'b0, rec_cmd = 1'b0;
  logic          play_sel = 1'b0, rec_sel = 1'b0;
  logic          done = 1'b0;
  logic          pdm_data = 1'b0;
  logic          playing_o, recording_o, serializer_enable_o, pdm_clk_o;
  logic          memory_rw_o, memory_0_enable_o, memory_1_enable_o;
  logic [3:0]    play_clip_o, record_clip_o;
  logic [AW-1:0] memory_address_o;
  logic [W-1:0]  memory_data_o;

  audio_record_play_core #(
    .WORD_LENGTH(W), .SYSTEM_FREQUENCY(100), .SAMPLING_FREQUENCY(10),
    .ADDR_WIDTH(AW), .MEMORY_DEPTH(DEPTH)
  ) dut (
    .clock_i(clk), .reset_i(reset_i),
    .play_command_i(play_cmd), .record_command_i(rec_cmd),
    .play_clip_select_i(play_sel), .record_clip_select_i(rec_sel),
    .playing_o(playing_o), .recording_o(recording_o),
    .play_clip_o(play_clip_o), .record_clip_o(record_clip_o),
    .serializer_done_i(done), .serializer_enable_o(serializer_enable_o),
    .pdm_clk_o(pdm_clk_o), .pdm_data_i(pdm_data),
    .memory_rw_o(memory_rw_o), .memory_address_o(memory_address_o),
    .memory_0_enable_o(memory_0_enable_o), .memory_1_enable_o(memory_1_enable_o),
    .memory_data_o(memory_data_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 record, 2 play. m_k is the index of the
  // current cycle inside RECORD; the PDM clock and sample points follow from it.
  int       m_mode = 0;
  int       m_addr = 0;
  int       m_k = 0;
  bit       m_psel = 0, m_rsel = 0, m_prev_p = 0, m_prev_r = 0, m_strobe = 0;
  logic [W-1:0] m_data = '0;
  bit       m_bits[$];

  always @(posedge clk or negedge reset_i) begin : model
    bit pe, re, nstrobe;
    int nmode, naddr;
    logic [W-1:0] word;
    if (!reset_i) begin
      m_mode = 0; m_addr = 0; m_k = 0; m_psel = 0; m_rsel = 0;
      m_prev_p = 0; m_prev_r = 0; m_strobe = 0; m_data = '0;
      m_bits.delete();
    end else begin
      pe = play_cmd && !m_prev_p;
      re = rec_cmd && !m_prev_r;
      m_prev_p = play_cmd;
      m_prev_r = rec_cmd;
      nmode = m_mode; naddr = m_addr; nstrobe = 0;
      if (m_mode == 0) begin
        m_psel = play_sel;
        m_rsel = rec_sel;
        if (re) begin
          nmode = 1; m_k = 0; m_bits.delete();
        end else if (pe) begin
          nmode = 2;
        end
      end else if (m_mode == 1) begin
        if (m_strobe) begin
          if (m_addr == DEPTH - 1) begin nmode = 0; naddr = 0; end
          else naddr = m_addr + 1;
        end
        if (m_k % PERIOD == HALF - 1) m_bits.push_back(pdm_data);
        if (m_bits.size() == W) begin
          word = '0;
          for (int i = 0; i < W; i++) word = {word[W-2:0], m_bits[i]};
          m_bits.delete();
          if (nmode == 1) begin nstrobe = 1; m_data = word; end
        end
        m_k++;
      end else begin
        if (done) begin
          if (m_addr == DEPTH - 1) begin nmode = 0; naddr = 0; end
          else naddr = m_addr + 1;
        end
      end
      m_mode = nmode; m_addr = naddr; m_strobe = nstrobe;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit e_rec, e_play, e_pdm;
    e_rec  = (m_mode == 1);
    e_play = (m_mode == 2);
    e_pdm  = e_rec && (((m_k / HALF) % 2) == 1);
    check("status", {recording_o, playing_o, serializer_enable_o, pdm_clk_o, memory_rw_o,
                     memory_0_enable_o, memory_1_enable_o},
          {e_rec, e_play, e_play, e_pdm, m_strobe,
           (e_play && !m_psel) || (m_strobe && !m_rsel),
           (e_play && m_psel) || (m_strobe && m_rsel)});
    check("clips", {play_clip_o, record_clip_o}, {4'(m_psel), 4'(m_rsel)});
    check("address", memory_address_o, 64'(m_addr));
    check("data", memory_data_o, m_data);
  end

  // Write strobe and PDM rise observation for the literal checks.
  logic [AW-1:0] obs_addr[$];
  logic [W-1:0]  obs_data[$];
  logic [1:0]    obs_en[$];
  int            rises[$];
  int            cyc = 0;
  logic          prev_pdm_n = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (memory_rw_o) begin
      obs_addr.push_back(memory_address_o);
      obs_data.push_back(memory_data_o);
      obs_en.push_back({memory_1_enable_o, memory_0_enable_o});
    end
    if (pdm_clk_o && !prev_pdm_n) rises.push_back(cyc);
    prev_pdm_n = pdm_clk_o;
  end

  // pdm_mode: 0 hold, 1 alternate, 2 random; data changes only after pdm_clk_o falls.
  int   pdm_mode = 0;
  logic last_pdm = 1'b0;

  task automatic tick();
    @(posedge clk);
    #2;
    if (!pdm_clk_o && last_pdm) begin
      if (pdm_mode == 1) pdm_data = ~pdm_data;
      else if (pdm_mode == 2) pdm_data = 1'($urandom_range(0, 1));
    end
    last_pdm = pdm_clk_o;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((recording_o || playing_o) && n < budget) begin tick(); n++; end
    check(name, {recording_o, playing_o}, 2'b00);
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); obs_en.delete(); rises.delete();
  endtask

  task automatic pulse_record();
    rec_cmd = 1'b1; tick(); rec_cmd = 1'b0;
  endtask

  initial begin
    // 1. reset state
    ticks(3);
    @(negedge clk);
    check("reset_outputs", {playing_o, recording_o, serializer_enable_o, pdm_clk_o, memory_rw_o,
                            memory_0_enable_o, memory_1_enable_o, play_clip_o, record_clip_o,
                            memory_address_o, memory_data_o}, 64'd0);
    tick(); reset_i = 1'b1; ticks(2);

    // 2. record all-ones into clip 1
    rec_sel = 1'b1; pdm_data = 1'b1; pdm_mode = 0; ticks(2);
    clear_obs();
    pulse_record();
    @(negedge clk);
    check("rec_entered", recording_o, 1'b1);
    wait_idle(2000, "rec_ones_timeout");
    check("rec_ones_count", obs_addr.size(), 4);
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      check("rec_ones_addr", obs_addr[i], 64'(i));
      check("rec_ones_data", obs_data[i], 16'hFFFF);
      check("rec_ones_en", obs_en[i], 2'b10);
    end
    if (rises.size() >= 2) check("pdm_period", rises[1] - rises[0], 10);
    else check("pdm_rises", rises.size(), 2);
    tick();
    check("idle_addr", memory_address_o, 0);

    // 3. alternating bits into clip 0
    rec_sel = 1'b0; pdm_data = 1'b1; pdm_mode = 1; ticks(2);
    clear_obs();
    pulse_record();
    wait_idle(2000, "rec_alt_timeout");
    if (obs_data.size() > 0) begin
      check("rec_alt_first", obs_data[0], 16'hAAAA);
      check("rec_alt_en", obs_en[0], 2'b01);
    end else check("rec_alt_count", obs_data.size(), 4);
    pdm_mode = 0;

    // 4. play clip 0 with four serializer pulses
    play_sel = 1'b0; ticks(2);
    play_cmd = 1'b1; tick(); play_cmd = 1'b0;
    @(negedge clk);
    check("play_entered", {playing_o, memory_0_enable_o, memory_1_enable_o, memory_rw_o}, 4'b1100);
    check("play_addr0", memory_address_o, 0);
    for (int i = 1; i <= 4; i++) begin
      ticks(3);
      done = 1'b1; tick(); done = 1'b0;
      @(negedge clk);
      if (i < 4) check("play_addr_step", memory_address_o, 64'(i));
      else check("play_end", {playing_o, memory_address_o}, 18'd0);
    end

    // 5. simultaneous edges: record wins; play edge while recording ignored
    rec_sel = 1'b1; play_sel = 1'b1; ticks(2);
    rec_cmd = 1'b1; play_cmd = 1'b1; tick();
    @(negedge clk);
    check("both_record_wins", {recording_o, playing_o}, 2'b10);
    play_cmd = 1'b0; ticks(3);
    play_cmd = 1'b1; ticks(3);
    check("play_edge_ignored", {recording_o, playing_o}, 2'b10);
    play_cmd = 1'b0; rec_cmd = 1'b0;
    wait_idle(2000, "both_timeout");

    // 6. reset mid-record at address 2
    rec_sel = 1'b0; pdm_mode = 2; ticks(2);
    pulse_record();
    begin
      int n;
      n = 0;
      while (memory_address_o != 2 && n < 2000) begin tick(); n++; end
      check("reach_addr2", memory_address_o, 2);
    end
    ticks(7);
    reset_i = 1'b0;
    #1;
    check("mid_reset", {recording_o, memory_address_o, memory_rw_o, memory_0_enable_o,
                        memory_1_enable_o, pdm_clk_o}, 22'd0);
    ticks(2);
    reset_i = 1'b1;
    ticks(2);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 39) == 0) play_cmd = ~play_cmd;
      if ($urandom_range(0, 59) == 0) rec_cmd = ~rec_cmd;
      if ($urandom_range(0, 29) == 0) play_sel = ~play_sel;
      if ($urandom_range(0, 29) == 0) rec_sel = ~rec_sel;
      done = ($urandom_range(0, 5) == 0);
      tick();
    end
    done = 1'b0; play_cmd = 1'b0; rec_cmd = 1'b0;
    wait_idle(3000, "final_timeout");
    ticks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
